encoder_scan_nbit: RTL
======================

// Module: encoder_scan_nbit
// PURPOSE
// - Sequential bit-scan encoder: the inverse of the N-bit binary-to-one-hot decoder.
// - Accepts a 2**N-bit vector and emits, one beat per cycle, the binary index of every set bit.
// - Emission order is ascending, from LSB to MSB.
// - Sits between request/flag vectors and binary-indexed consumers (mux selects, display, counters).
// - Both sides use valid/ready handshakes.
// PARAMETERS
// - N   default 4   index width; input vector width is 2**N
// PORTS
// - clk         in   1       system clock; all state updates on rising edge
// - reset       in   1       synchronous, active-high reset
// - in_valid    in   1       inEncoder holds a vector to encode
// - in_ready    out  1       block can accept a vector (high only in IDLE)
// - inEncoder   in   2**N    vector to scan
// - out_valid   out  1       outEncoder/out_seq/out_last hold a valid beat
// - out_ready   in   1       consumer accepts the current beat
// - outEncoder  out  N       binary index of the lowest still-pending set bit
// - out_seq     out  N+1     0-based beat number within the current vector
// - out_last    out  1       current beat is the final beat of this vector
// - zero_drop   out  1       one-cycle pulse: an all-zero vector was accepted and discarded
// BEHAVIOUR
// - Reset (reset=1 at clk edge):
//   - state=IDLE, pending=0, out_seq=0, zero_drop=0.
//   - Outputs after reset: in_ready=1, out_valid=0, outEncoder=0, out_last=0.
//   - Reset overrides any handshake in the same cycle; a scan in progress is abandoned, no further beats.
// - State IDLE:
//   - in_ready=1, out_valid=0.
//   - On in_valid at an edge with nonzero inEncoder: pending<=inEncoder, out_seq<=0, go SCAN.
//   - On in_valid at an edge with inEncoder==0: stay IDLE; zero_drop=1 for exactly the next cycle.
// - State SCAN:
//   - in_ready=0, out_valid=1.
//   - outEncoder = index of the lowest set bit of pending, derived from registered state only.
//   - out_last = 1 iff pending has exactly one set bit.
//   - On out_valid&&out_ready: clear that bit in pending and increment out_seq.
//   - If that beat had out_last=1: go IDLE, out_seq<=0.
// - Latency and throughput:
//   - Vector accepted at edge t; first beat is valid in the cycle after t.
//   - With out_ready held high: popcount(vector) beats on consecutive cycles.
//   - One IDLE cycle follows before the next vector can be accepted.
// - Backpressure:
//   - While out_valid=1 and out_ready=0, outEncoder, out_seq and out_last are held stable.
// - Outputs when out_valid=0: outEncoder=0, out_last=0. out_seq is don't-care for consumers.
// - Widths and boundaries:
//   - out_seq is N+1 bits so it holds 0..2**N-1 without wrap.
//   - The all-ones vector yields 2**N beats, the last with out_seq=2**N-1.
//   - Bit 0 set yields index 0, which is distinct from the idle value only via out_valid.
//   - An all-zero vector never raises out_valid.
// - in_valid while in_ready=0 is ignored; the source must hold data until accepted.
// TESTING (N=4)
// - 16'h0001 accepted, out_ready=1:
//   - next cycle one beat outEncoder=0, out_seq=0, out_last=1.
//   - in_ready returns high the cycle after.
// - 16'h8421, out_ready=1:
//   - beats 0,5,10,15 on consecutive cycles, out_seq 0..3, out_last only on index 15.
//   - in_ready low for those 4 cycles.
// - 16'h0006, out_ready low 3 cycles then high:
//   - outEncoder=1, out_seq=0, out_last=0 held 3 cycles.
//   - then beats 1 and 2, out_last on 2.
// - 16'h0000 accepted: zero_drop=1 for exactly one cycle; out_valid stays 0; in_ready stays 1.
// - 16'hFFFF, reset asserted after beat 3 is accepted:
//   - next cycle out_valid=0, in_ready=1.
//   - then 16'h0100 gives a single beat outEncoder=8, out_seq=0, out_last=1.
// - 16'hFFFF, out_ready=1: 16 beats indices 0..15; out_seq=15 with out_last=1; no wrap.

Source files
------------

// File: rtl/encoder_scan_nbit.sv
// Sequential bit-scan encoder: emits the binary index of every set bit of a
// 2**N-bit vector, lowest first, one valid/ready beat per cycle.
//   state | meaning
//   IDLE  | waiting for a vector; in_ready high
//   SCAN  | presenting lowest pending index; out_valid high
module encoder_scan_nbit #(
  parameter int N = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2**N-1:0] inEncoder,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    outEncoder,
  output logic [N:0]      out_seq,
  output logic            out_last,
  output logic            zero_drop
);

  localparam int W = 2**N;

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t         state;
  state_t         state_nxt;
  logic [W-1:0]   pending;
  logic [N-1:0]   low_idx;
  logic           single;
  logic           accept;
  logic           load;
  logic           beat;

  // Priority scan from the top so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = N'(i);
    end
  end

  assign single = (pending != '0) && ((pending & (pending - W'(1))) == '0);
  assign accept = (state == IDLE) && in_valid;
  assign load   = accept && (inEncoder != '0);
  assign beat   = (state == SCAN) && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (load) state_nxt = SCAN;
      SCAN: if (out_ready && single) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE);
    out_valid  = (state == SCAN);
    outEncoder = (state == SCAN) ? low_idx : '0;
    out_last   = (state == SCAN) && single;
  end

  // pending & (pending - 1) clears exactly the bit that was just emitted.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= '0;
      out_seq   <= '0;
      zero_drop <= 1'b0;
    end else begin
      zero_drop <= accept && (inEncoder == '0);
      if (load) begin
        pending <= inEncoder;
        out_seq <= '0;
      end else if (beat) begin
        pending <= pending & (pending - W'(1));
        out_seq <= single ? '0 : out_seq + (N+1)'(1);
      end
    end
  end

endmodule
